// File: rtl/branch_cmp_ctrl.sv
// ---------------------------------------------------------------------------
// branch_cmp_ctrl
// Sequences the ID-stage branch comparator. A branch request is latched in
// IDLE, waits in WAIT_OPND until the hazard unit reports forwarded operands,
// is resolved from the comparator flags in RESOLVE and retires in DONE with
// one-cycle ack / redirect / link-write pulses.
//
// Optional feature: define BR_CMP_STATS_EN to build the saturating
// taken_cnt / stall_cnt statistics counters; otherwise both are tied to 0.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   br_valid, br_type   branch request and type (0 BEQ .. 6 BIOAL, 7 rsvd)
//   pc_id, imm16        branch PC and offset field
//   opnd_ready          comparator operands forwarded and valid
//   flush               abort in-flight request
//   cmp_zero/gtz/ltz/isp comparator flags
//   stall               freeze IF/ID (combinational)
//   br_ack              request retired (pulse)
//   redirect_valid/_pc  branch taken (pulse) and target PC
//   link_we/_addr/_data $ra write for BIOAL (pulse), reg 31, pc_id + 8
//   err                 sticky timeout / reserved-type flag
//   taken_cnt, stall_cnt statistics counters
// ---------------------------------------------------------------------------
module branch_cmp_ctrl #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             br_valid,
   input  logic [2:0]       br_type,
   input  logic [31:0]      pc_id,
   input  logic [15:0]      imm16,
   input  logic             opnd_ready,
   input  logic             flush,
   input  logic             cmp_zero,
   input  logic             cmp_gtz,
   input  logic             cmp_ltz,
   input  logic             cmp_isp,
   output logic             stall,
   output logic             br_ack,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             link_we,
   output logic [4:0]       link_addr,
   output logic [31:0]      link_data,
   output logic             err,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_OPND,
      ST_RESOLVE,
      ST_DONE
   } state_t;

   localparam logic [2:0] T_BEQ   = 3'd0;
   localparam logic [2:0] T_BNE   = 3'd1;
   localparam logic [2:0] T_BGTZ  = 3'd2;
   localparam logic [2:0] T_BLEZ  = 3'd3;
   localparam logic [2:0] T_BLTZ  = 3'd4;
   localparam logic [2:0] T_BGEZ  = 3'd5;
   localparam logic [2:0] T_BIOAL = 3'd6;
   localparam logic [2:0] T_RSVD  = 3'd7;

   localparam int WCNT_W = $clog2(WAIT_MAX + 1);
   // Counter value in the last allowed wait cycle: WAIT_OPND lasts at most
   // WAIT_MAX cycles before the request is retired as a timeout.
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

   state_t              state_q, state_d;
   logic [2:0]          type_q, type_d;
   logic [31:0]         pc_q, pc_d;
   logic [15:0]         imm_q, imm_d;
   logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [31:0]         redirect_pc_q, redirect_pc_d;
   logic [31:0]         link_data_q, link_data_d;
   logic                br_ack_q, br_ack_d;
   logic                redirect_valid_q, redirect_valid_d;
   logic                link_we_q, link_we_d;
   logic                err_q, err_d;
   logic                taken_now;

   // pc + 4 + (sign-extended imm << 2), wrapping modulo 2^32
   function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                 input logic [15:0] imm);
      logic signed [31:0] off;
      off = {{14{imm[15]}}, imm, 2'b00};
      return pc + 32'd4 + $unsigned(off);
   endfunction

   function automatic logic resolve_taken(input logic [2:0] t,
                                          input logic z, input logic g,
                                          input logic l, input logic o);
      case (t)
         T_BEQ:   return z;
         T_BNE:   return !z;
         T_BGTZ:  return g;
         T_BLEZ:  return !g;
         T_BLTZ:  return l;
         T_BGEZ:  return !l;
         T_BIOAL: return o;
         default: return 1'b0;
      endcase
   endfunction

   assign taken_now = resolve_taken(type_q, cmp_zero, cmp_gtz, cmp_ltz, cmp_isp);

   always_comb begin
      state_d          = state_q;
      type_d           = type_q;
      pc_d             = pc_q;
      imm_d            = imm_q;
      wait_cnt_d       = wait_cnt_q;
      redirect_pc_d    = redirect_pc_q;
      link_data_d      = link_data_q;
      err_d            = err_q;
      br_ack_d         = 1'b0;
      redirect_valid_d = 1'b0;
      link_we_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // flush beats a simultaneous request: nothing is latched
            if (br_valid && !flush) begin
               type_d     = br_type;
               pc_d       = pc_id;
               imm_d      = imm16;
               wait_cnt_d = '0;
               state_d    = opnd_ready ? ST_RESOLVE : ST_WAIT_OPND;
            end
         end
         ST_WAIT_OPND: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (opnd_ready) begin
               state_d = ST_RESOLVE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               err_d    = 1'b1;
               br_ack_d = 1'b1;
               state_d  = ST_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
         end
         ST_RESOLVE: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               if (type_q == T_RSVD) err_d = 1'b1;
               redirect_pc_d    = branch_target(pc_q, imm_q);
               link_data_d      = pc_q + 32'd8;
               br_ack_d         = 1'b1;
               redirect_valid_d = taken_now;
               link_we_d        = (type_q == T_BIOAL) && taken_now;
               state_d          = ST_DONE;
            end
         end
         default: begin
            // DONE: pulses are already on the registered outputs
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         type_q           <= '0;
         pc_q             <= '0;
         imm_q            <= '0;
         wait_cnt_q       <= '0;
         redirect_pc_q    <= '0;
         link_data_q      <= '0;
         err_q            <= 1'b0;
         br_ack_q         <= 1'b0;
         redirect_valid_q <= 1'b0;
         link_we_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         type_q           <= type_d;
         pc_q             <= pc_d;
         imm_q            <= imm_d;
         wait_cnt_q       <= wait_cnt_d;
         redirect_pc_q    <= redirect_pc_d;
         link_data_q      <= link_data_d;
         err_q            <= err_d;
         br_ack_q         <= br_ack_d;
         redirect_valid_q <= redirect_valid_d;
         link_we_q        <= link_we_d;
      end
   end

   // Gated by reset so nothing escapes while reset is held low
   assign stall = reset && ((state_q == ST_IDLE && br_valid && !flush) ||
                            state_q == ST_WAIT_OPND || state_q == ST_RESOLVE);

   assign br_ack         = br_ack_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign link_we        = link_we_q;
   assign link_addr      = 5'd31;
   assign link_data      = link_data_q;
   assign err            = err_q;

`ifdef BR_CMP_STATS_EN
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      taken_cnt_d = taken_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (redirect_valid_q) taken_cnt_d = sat_inc(taken_cnt_q);
      if (stall)            stall_cnt_d = sat_inc(stall_cnt_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         taken_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         taken_cnt_q <= taken_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign taken_cnt = taken_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   assign taken_cnt = '0;
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_cmp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_cmp_ctrl
// Randomized and directed stimulus for branch_cmp_ctrl, checked cycle by
// cycle against a transaction-level reference model (latency from the
// operand-ready delay, taken rule per branch type, target arithmetic,
// sticky err and statistics totals).
// ---------------------------------------------------------------------------
module tb_branch_cmp_ctrl;

   localparam int WAIT_MAX = 15;
   localparam int CNT_W    = 32;
`ifdef BR_CMP_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk;
   logic             reset;
   logic             br_valid;
   logic [2:0]       br_type;
   logic [31:0]      pc_id;
   logic [15:0]      imm16;
   logic             opnd_ready;
   logic             flush;
   logic             cmp_zero, cmp_gtz, cmp_ltz, cmp_isp;
   logic             stall, br_ack, redirect_valid, link_we, err;
   logic [31:0]      redirect_pc, link_data;
   logic [4:0]       link_addr;
   logic [CNT_W-1:0] taken_cnt, stall_cnt;

   int n_vec = 0;
   int n_err = 0;

   // reference-model state
   logic err_m;
   int   stall_m;
   int   taken_m;

   branch_cmp_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
      .pc_id(pc_id), .imm16(imm16), .opnd_ready(opnd_ready), .flush(flush),
      .cmp_zero(cmp_zero), .cmp_gtz(cmp_gtz), .cmp_ltz(cmp_ltz),
      .cmp_isp(cmp_isp), .stall(stall), .br_ack(br_ack),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .link_we(link_we), .link_addr(link_addr), .link_data(link_data),
      .err(err), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_taken(input logic [2:0] t, input logic z,
                                      input logic g, input logic l,
                                      input logic o);
      case (t)
         3'd0: return z;
         3'd1: return !z;
         3'd2: return g;
         3'd3: return !g;
         3'd4: return l;
         3'd5: return !l;
         3'd6: return o;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk_stats();
      chk("taken_cnt", taken_cnt, STATS ? 32'(taken_m) : 32'd0);
      chk("stall_cnt", stall_cnt, STATS ? 32'(stall_m) : 32'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         br_valid = 1'b0; flush = 1'b0; opnd_ready = 1'b0;
         #1;
         chk("idle_stall", stall, 1'b0);
         chk("idle_ack", br_ack, 1'b0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; br_valid = 1'b0; flush = 1'b0; opnd_ready = 1'b0;
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_ack", br_ack, 1'b0);
      chk("rst_redir_v", redirect_valid, 1'b0);
      chk("rst_link_we", link_we, 1'b0);
      chk("rst_redir_pc", redirect_pc, 32'd0);
      chk("rst_link_data", link_data, 32'd0);
      chk("rst_err", err, 1'b0);
      chk("rst_link_addr", 32'(link_addr), 32'd31);
      chk("rst_taken_cnt", taken_cnt, 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      err_m = 1'b0; stall_m = 0; taken_m = 0;
   endtask

   // One complete branch. Operands become ready after k cycles (k=0: ready
   // in the request cycle). drop releases br_valid early and scribbles on
   // the request fields to show the latched copy is used.
   task automatic run_br(input logic [2:0] t, input logic [31:0] pc,
                         input logic [15:0] imm, input logic z, input logic g,
                         input logic l, input logic o, input int k,
                         input bit drop);
      bit          tmo, tk, lk;
      logic        e_new;
      int          done_c, off;
      logic [31:0] tgt;
      tmo    = (k > WAIT_MAX);
      done_c = tmo ? WAIT_MAX + 2 : k + 3;
      tk     = tmo ? 1'b0 : model_taken(t, z, g, l, o);
      lk     = tk && (t == 3'd6);
      e_new  = err_m | tmo | (!tmo && t == 3'd7);
      off    = $signed(imm);
      tgt    = pc + 32'd4 + 32'(off * 4);
      for (int c = 1; c <= done_c; c++) begin
         @(negedge clk);
         if (c == 1) begin
            br_valid = 1'b1; br_type = t; pc_id = pc; imm16 = imm;
            cmp_zero = z; cmp_gtz = g; cmp_ltz = l; cmp_isp = o;
         end else if (drop) begin
            br_valid = 1'b0; br_type = 3'($urandom);
            pc_id = $urandom; imm16 = 16'($urandom);
         end
         opnd_ready = (c > k);
         flush = 1'b0;
         #1;
         chk("stall", stall, c < done_c);
         chk("br_ack", br_ack, c == done_c);
         chk("redirect_valid", redirect_valid, (c == done_c) && tk);
         chk("link_we", link_we, (c == done_c) && lk);
         chk("err", err, (c == done_c) ? e_new : err_m);
         if (c == done_c && !tmo) begin
            chk("redirect_pc", redirect_pc, tgt);
            chk("link_data", link_data, pc + 32'd8);
            chk("link_addr", 32'(link_addr), 32'd31);
         end
      end
      err_m   = e_new;
      stall_m = stall_m + done_c - 1;
      taken_m = taken_m + int'(tk);
      @(negedge clk);
      br_valid = 1'b0; opnd_ready = 1'b0;
      #1;
      chk("post_stall", stall, 1'b0);
      chk("post_ack", br_ack, 1'b0);
      chk_stats();
   endtask

   // Request, then flush in cycle 2 (WAIT_OPND if k>0, RESOLVE if k==0)
   task automatic flush_br(input logic [2:0] t, input int k);
      @(negedge clk);
      br_valid = 1'b1; br_type = t; pc_id = $urandom; imm16 = 16'($urandom);
      opnd_ready = (k == 0); flush = 1'b0;
      #1;
      chk("fl_stall1", stall, 1'b1);
      @(negedge clk);
      flush = 1'b1; br_valid = 1'b0;
      #1;
      chk("fl_stall2", stall, 1'b1);
      chk("fl_ack2", br_ack, 1'b0);
      stall_m = stall_m + 2;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("fl_stall3", stall, 1'b0);
      chk("fl_ack3", br_ack, 1'b0);
      chk("fl_redir", redirect_valid, 1'b0);
      chk("fl_link", link_we, 1'b0);
      chk("fl_err", err, err_m);
      idle(2);
      chk_stats();
   endtask

   initial begin
      reset = 1'b0; br_valid = 1'b0; br_type = '0; pc_id = '0; imm16 = '0;
      opnd_ready = 1'b0; flush = 1'b0;
      cmp_zero = 1'b0; cmp_gtz = 1'b0; cmp_ltz = 1'b0; cmp_isp = 1'b0;
      err_m = 1'b0; stall_m = 0; taken_m = 0;
      do_reset();
      idle(1);

      // BEQ taken: target 0x00003014, ack in cycle 3
      run_br(3'd0, 32'h0000_3000, 16'h0004, 1, 0, 0, 0, 0, 0);
      // BNE with equal operands: not taken
      run_br(3'd1, 32'h0000_4000, 16'hFFFF, 1, 0, 0, 0, 0, 0);
      // BIOAL taken: target 0x00003004, link 0x00003010
      run_br(3'd6, 32'h0000_3008, 16'hFFFE, 0, 0, 0, 1, 0, 0);
      // target wrap-around past 2^32
      run_br(3'd0, 32'hFFFF_FFF0, 16'h0010, 1, 0, 0, 0, 0, 0);

      // BGTZ with operands late by 3 cycles: 5 stall cycles, 1 taken
      do_reset();
      run_br(3'd2, 32'h0000_1000, 16'h0020, 0, 1, 0, 0, 3, 0);
      chk("tp_stall_cnt", stall_cnt, STATS ? 32'd5 : 32'd0);
      chk("tp_taken_cnt", taken_cnt, STATS ? 32'd1 : 32'd0);

      // operands ready on the last allowed wait cycle: no timeout
      run_br(3'd5, $urandom, 16'($urandom), 0, 0, 0, 0, WAIT_MAX, 0);
      // operands never ready: timeout sets err
      run_br(3'd0, 32'h0000_2000, 16'h0001, 1, 0, 0, 0, WAIT_MAX + 3, 0);
      // reserved type: not taken, err stays set
      run_br(3'd7, 32'h0000_5000, 16'h0001, 1, 1, 1, 1, 0, 1);

      // flush in RESOLVE and in WAIT_OPND
      flush_br(3'd0, 0);
      flush_br(3'd3, 4);

      // flush beats a simultaneous request in IDLE
      @(negedge clk);
      br_valid = 1'b1; flush = 1'b1; br_type = 3'd0; opnd_ready = 1'b1;
      #1;
      chk("fl_idle_stall", stall, 1'b0);
      idle(3);
      chk_stats();

      // clear err, then randomized traffic
      do_reset();
      for (int n = 0; n < 150; n++) begin
         int k;
         k = ($urandom_range(0, 7) == 0) ? $urandom_range(WAIT_MAX - 1, WAIT_MAX + 2)
                                         : $urandom_range(0, 4);
         run_br(3'($urandom_range(0, 7)), $urandom, 16'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                k, 1'($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end

      // reset mid-WAIT_OPND: everything returns to 0 immediately
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         br_valid = 1'b1; br_type = 3'd1; pc_id = $urandom;
         imm16 = 16'($urandom); opnd_ready = 1'b0; flush = 1'b0;
      end
      do_reset();
      idle(2);
      chk_stats();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
